branch_sched: RTL and testbench

Branch scheduler for the out-of-order core. It sits between rename/dispatch and `branch_ex` and buffers branch instructions (B, BL, CBZ, CBNZ, RET) in a small circular queue. It captures the source operand from the CDB and issues branches to `branch_ex` strictly in program order. At most one branch is unresolved at a time, so a mispredict squashes every queued (younger) branch before any of them can issue.

---
 rtl/branch_sched.sv | 165 ++++++++++++++++
 tb/tb_branch_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_sched.sv
// In-order branch scheduler: circular queue with CDB wakeup, issues one branch at a time.
// Optional macro BRANCH_SCHED_CDB_BYPASS_EN lets a head woken by the CDB this cycle issue immediately.
module branch_sched #(
  parameter int XLEN   = 32,  // matches core_pkg::XLEN
  parameter int PHYS_W = 6,   // matches core_pkg::LOG2_PREGS
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      dispatch_valid,
  output logic                      dispatch_ready,
  input  logic [11:0]               dispatch_op,
  input  logic [PHYS_W-1:0]         dispatch_dst_tag,
  input  logic [PHYS_W-1:0]         dispatch_src1_tag,
  input  logic                      dispatch_src1_rdy,
  input  logic [XLEN-1:0]           dispatch_src1_val,
  input  logic [XLEN-1:0]           dispatch_pc,
  input  logic [XLEN-1:0]           dispatch_imm,
  input  logic [5:0]                dispatch_rob_tag,
  input  logic                      cdb_valid,
  input  logic [PHYS_W-1:0]         cdb_tag,
  input  logic [XLEN-1:0]           cdb_value,
  input  logic                      branch_mispredict,
  output logic                      issue_valid,
  output logic [11:0]               issue_op,
  output logic [PHYS_W-1:0]         issue_dst_tag,
  output logic [XLEN-1:0]           issue_src1_val,
  output logic [XLEN-1:0]           issue_pc,
  output logic [XLEN-1:0]           issue_imm,
  output logic [5:0]                issue_rob_tag,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUED, RESOLVE} state_t;

  state_t state_reg, state_next;
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [11:0]       ent_op  [DEPTH];
  logic [PHYS_W-1:0] ent_dst [DEPTH];
  logic [PHYS_W-1:0] ent_tag [DEPTH];
  logic              ent_rdy [DEPTH];
  logic [XLEN-1:0]   ent_val [DEPTH];
  logic [XLEN-1:0]   ent_pc  [DEPTH];
  logic [XLEN-1:0]   ent_imm [DEPTH];
  logic [5:0]        ent_rob [DEPTH];

  logic [DEPTH-1:0] cdb_hit;
  logic             head_ready;
  logic [XLEN-1:0]  head_val;
  logic             can_issue, mispredict_clear, push, pop;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
      assign cdb_hit[gi] = cdb_valid && !ent_rdy[gi] && (ent_tag[gi] == cdb_tag);
    end
  endgenerate

  assign dispatch_ready = (count_reg < CNT_W'(DEPTH));
  assign occupancy      = count_reg;

  always_comb begin
    head_ready = ent_rdy[head_reg];
    head_val   = ent_val[head_reg];
`ifdef BRANCH_SCHED_CDB_BYPASS_EN
    if (cdb_hit[head_reg]) begin
      head_ready = 1'b1;
      head_val   = cdb_value;
    end
`endif
  end

  always_comb begin
    mispredict_clear = (state_reg == RESOLVE) && branch_mispredict;
    can_issue = (count_reg != '0) && head_ready &&
                ((state_reg == IDLE) || ((state_reg == RESOLVE) && !branch_mispredict));
    push = dispatch_valid && dispatch_ready && !flush && !mispredict_clear;
    pop  = can_issue && !flush;

    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + 1'b1;
    else if (pop && !push) count_next = count_reg - 1'b1;

    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = can_issue ? ISSUED : IDLE;
      ISSUED:  state_next = RESOLVE;
      RESOLVE: state_next = can_issue ? ISSUED : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      issue_valid    <= 1'b0;
      issue_op       <= '0;
      issue_dst_tag  <= '0;
      issue_src1_val <= '0;
      issue_pc       <= '0;
      issue_imm      <= '0;
      issue_rob_tag  <= '0;
    end else if (flush) begin
      state_reg   <= IDLE;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      issue_valid <= 1'b0;
    end else if (mispredict_clear) begin
      // Everything queued is younger than the mispredicted branch.
      state_reg   <= IDLE;
      tail_reg    <= head_reg;
      count_reg   <= '0;
      issue_valid <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      issue_valid <= pop;
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop) begin
        head_reg       <= head_reg + 1'b1;
        issue_op       <= ent_op[head_reg];
        issue_dst_tag  <= ent_dst[head_reg];
        issue_src1_val <= head_val;
        issue_pc       <= ent_pc[head_reg];
        issue_imm      <= ent_imm[head_reg];
        issue_rob_tag  <= ent_rob[head_reg];
      end
    end
  end

  // Entry storage; stale contents of invalid slots are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (tail_reg == PTR_W'(i))) begin
        ent_op[i]  <= dispatch_op;
        ent_dst[i] <= dispatch_dst_tag;
        ent_tag[i] <= dispatch_src1_tag;
        ent_pc[i]  <= dispatch_pc;
        ent_imm[i] <= dispatch_imm;
        ent_rob[i] <= dispatch_rob_tag;
        if (cdb_valid && (cdb_tag == dispatch_src1_tag)) begin
          ent_rdy[i] <= 1'b1;
          ent_val[i] <= cdb_value;
        end else begin
          ent_rdy[i] <= dispatch_src1_rdy;
          ent_val[i] <= dispatch_src1_val;
        end
      end else if (cdb_hit[i]) begin
        ent_rdy[i] <= 1'b1;
        ent_val[i] <= cdb_value;
      end
    end
  end

endmodule

// File: tb/tb_branch_sched.sv
// Directed self-checking bench for branch_sched (DEPTH=4, XLEN=32, PHYS_W=6).
module tb_branch_sched;
  logic        clk = 1'b0;
  logic        reset, flush;
  logic        dispatch_valid, dispatch_ready;
  logic [11:0] dispatch_op;
  logic [5:0]  dispatch_dst_tag, dispatch_src1_tag;
  logic        dispatch_src1_rdy;
  logic [31:0] dispatch_src1_val, dispatch_pc, dispatch_imm;
  logic [5:0]  dispatch_rob_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        branch_mispredict;
  logic        issue_valid;
  logic [11:0] issue_op;
  logic [5:0]  issue_dst_tag;
  logic [31:0] issue_src1_val, issue_pc, issue_imm;
  logic [5:0]  issue_rob_tag;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;

`ifdef BRANCH_SCHED_CDB_BYPASS_EN
  localparam int WAKE_OFS = 0;
`else
  localparam int WAKE_OFS = 1;
`endif

  branch_sched #(.XLEN(32), .PHYS_W(6), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_dst_tag(dispatch_dst_tag),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src1_rdy(dispatch_src1_rdy),
    .dispatch_src1_val(dispatch_src1_val), .dispatch_pc(dispatch_pc),
    .dispatch_imm(dispatch_imm), .dispatch_rob_tag(dispatch_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .branch_mispredict(branch_mispredict),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
    .issue_src1_val(issue_src1_val), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_rob_tag(issue_rob_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dispatch(input logic [5:0] src_tag, input logic rdy,
                                input logic [31:0] val, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [5:0] rob);
    dispatch_valid    = 1'b1;
    dispatch_op       = {6'h2D, rob};
    dispatch_dst_tag  = rob + 6'd1;
    dispatch_src1_tag = src_tag;
    dispatch_src1_rdy = rdy;
    dispatch_src1_val = val;
    dispatch_pc       = pc;
    dispatch_imm      = imm;
    dispatch_rob_tag  = rob;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_op = '0;
    dispatch_dst_tag = '0; dispatch_src1_tag = '0; dispatch_src1_rdy = 1'b0;
    dispatch_src1_val = '0; dispatch_pc = '0; dispatch_imm = '0; dispatch_rob_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; branch_mispredict = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_issue_valid", issue_valid, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_ready", dispatch_ready, 1);
    check("reset_issue_pc", issue_pc, 0);

    // CBZ with ready source: issues one cycle after being queued
    drive_dispatch(6'd3, 1'b1, 32'h0, 32'h100, 32'h20, 6'd1);
    tick();
    dispatch_valid = 1'b0;
    check("cbz_occ_after_dispatch", occupancy, 1);
    check("cbz_no_issue_yet", issue_valid, 0);
    tick();
    check("cbz_issue_valid", issue_valid, 1);
    check("cbz_issue_pc", issue_pc, 32'h100);
    check("cbz_issue_imm", issue_imm, 32'h20);
    check("cbz_issue_val", issue_src1_val, 0);
    check("cbz_issue_op", issue_op, {6'h2D, 6'd1});
    check("cbz_occ_zero", occupancy, 0);
    tick();
    check("cbz_pulse_one_cycle", issue_valid, 0);
    tick();

    // CBNZ waiting on tag 5, woken by the CDB three cycles later
    drive_dispatch(6'd5, 1'b0, 32'h0, 32'h140, 32'h8, 6'd2);
    tick();
    dispatch_valid = 1'b0;
    tick(); check("cbnz_wait1", issue_valid, 0);
    tick(); check("cbnz_wait2", issue_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_value = 32'd7;
    tick();
    cdb_valid = 1'b0;
    for (int c = 0; c <= 1; c++) begin
      check("cbnz_issue_timing", issue_valid, (c == WAKE_OFS) ? 1 : 0);
      if (c == WAKE_OFS) begin
        check("cbnz_src1_val", issue_src1_val, 32'd7);
        check("cbnz_rob", issue_rob_tag, 6'd2);
      end
      tick();
    end
    tick(); tick();

    // Fill the queue behind a blocked head, then drain in order
    drive_dispatch(6'd9, 1'b0, 32'h0, 32'h200, 32'h4, 6'd10); tick();
    for (int i = 1; i < 4; i++) begin
      drive_dispatch(6'd40, 1'b1, 32'h10 + i, 32'h200 + 4 * i, 32'h4, 6'd10 + 6'(i));
      tick();
    end
    check("full_occ", occupancy, 4);
    check("full_ready_low", dispatch_ready, 0);
    drive_dispatch(6'd41, 1'b1, 32'h0, 32'h300, 32'h4, 6'd50);
    tick();
    dispatch_valid = 1'b0;
    check("full_drop_occ", occupancy, 4);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_value = 32'h55;
    for (int c = 0; c < 10; c++) begin
      tick();
      cdb_valid = 1'b0;
      if (c >= WAKE_OFS && ((c - WAKE_OFS) % 2 == 0) && (c - WAKE_OFS) < 8) begin
        check("drain_issue", issue_valid, 1);
        check("drain_rob", issue_rob_tag, 6'd10 + 6'((c - WAKE_OFS) / 2));
        if (c == WAKE_OFS) check("drain_head_val", issue_src1_val, 32'h55);
      end else begin
        check("drain_gap", issue_valid, 0);
      end
    end
    check("drain_occ", occupancy, 0);

    // Mispredict on the first of three queued branches
    drive_dispatch(6'd40, 1'b1, 32'h1, 32'h400, 32'h4, 6'd20); tick();
    drive_dispatch(6'd40, 1'b1, 32'h2, 32'h404, 32'h4, 6'd21); tick();
    check("mp_first_issue", issue_valid, 1);
    check("mp_first_rob", issue_rob_tag, 6'd20);
    drive_dispatch(6'd40, 1'b1, 32'h3, 32'h408, 32'h4, 6'd22); tick();
    dispatch_valid = 1'b0;
    check("mp_resolve_no_issue", issue_valid, 0);
    check("mp_occ_before", occupancy, 2);
    branch_mispredict = 1'b1;
    tick();
    branch_mispredict = 1'b0;
    check("mp_occ_cleared", occupancy, 0);
    for (int c = 0; c < 4; c++) begin
      check("mp_no_issue", issue_valid, 0);
      tick();
    end

    // Flush coincident with a dispatch while two entries wait
    drive_dispatch(6'd12, 1'b0, 32'h0, 32'h500, 32'h4, 6'd25); tick();
    drive_dispatch(6'd12, 1'b0, 32'h0, 32'h504, 32'h4, 6'd26); tick();
    check("flush_occ_before", occupancy, 2);
    drive_dispatch(6'd40, 1'b1, 32'h0, 32'h508, 32'h4, 6'd27);
    flush = 1'b1;
    tick();
    flush = 1'b0; dispatch_valid = 1'b0;
    check("flush_occ", occupancy, 0);
    check("flush_issue_valid", issue_valid, 0);
    check("flush_ready", dispatch_ready, 1);
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_value = 32'h99;
    tick();
    cdb_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("flush_no_issue", issue_valid, 0);
      tick();
    end

    // Six single branches walk the pointers past the wrap point
    for (int i = 0; i < 6; i++) begin
      drive_dispatch(6'd40, 1'b1, 32'h0, 32'h600 + 4 * i, 32'h4, 6'd30 + 6'(i));
      tick();
      dispatch_valid = 1'b0;
      tick();
      check("wrap_issue", issue_valid, 1);
      check("wrap_rob", issue_rob_tag, 6'd30 + 6'(i));
      check("wrap_pc", issue_pc, 32'h600 + 4 * i);
      tick();
    end
    check("wrap_occ", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
